// File: rtl/ramb16_port_arb_pkg.sv
// rtl/ramb16_port_arb_pkg.sv - shared FSM encoding and parity-width helper for the RAMB16 port arbiter
package ramb16_port_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    // One parity bit accompanies every data byte of a RAMB16 port.
    function automatic int par_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a single priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours requester 0 on a tie, 1 favours requester 1
    logic ptr_q;
    logic ptr_d;

    // Combinational grant; on a tie the requester not granted last wins
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register, reset to favour requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ramb16_port_arb.sv
// rtl/ramb16_port_arb.sv - two-requester arbiter driving one RAMB16 port with optional zero-fill after reset
module ramb16_port_arb
    import ramb16_port_arb_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               REQ0,
    input  logic                               REQ1,
    input  logic                               WR0,
    input  logic                               WR1,
    input  logic [ADDR_W-1:0]                  ADDR0,
    input  logic [ADDR_W-1:0]                  ADDR1,
    input  logic [DATA_W-1:0]                  DI0,
    input  logic [DATA_W-1:0]                  DI1,
    input  logic [par_w(DATA_W)-1:0]           DIP0,
    input  logic [par_w(DATA_W)-1:0]           DIP1,
    input  logic [par_w(DATA_W)-1:0]           BE0,
    input  logic [par_w(DATA_W)-1:0]           BE1,
    output logic                               GNT0,
    output logic                               GNT1,
    output logic                               RVALID0,
    output logic                               RVALID1,
    output logic [DATA_W+par_w(DATA_W)-1:0]    RDATA0,
    output logic [DATA_W+par_w(DATA_W)-1:0]    RDATA1,
    output logic                               RAM_EN,
    output logic [par_w(DATA_W)-1:0]           RAM_WE,
    output logic [ADDR_W-1:0]                  RAM_ADDR,
    output logic [DATA_W-1:0]                  RAM_DI,
    output logic [par_w(DATA_W)-1:0]           RAM_DIP,
    input  logic [DATA_W-1:0]                  RAM_DO,
    input  logic [par_w(DATA_W)-1:0]           RAM_DOP,
    output logic                               BUSY
);

    localparam int PW = par_w(DATA_W);

    arb_state_e        state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ram_en_q,  ram_en_d;
    logic [PW-1:0]     ram_we_q,  ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_di_q,  ram_di_d;
    logic [PW-1:0]     ram_dip_q, ram_dip_d;
    logic              rd_q,      rd_d;
    logic              rd_id_q,   rd_id_d;
    logic [1:0]        rvalid_q,  rvalid_d;

    logic       run;
    logic [1:0] gnt;

    assign run = (state_q == ST_RUN);

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (run),
        .req   ({REQ1, REQ0}),
        .gnt   (gnt)
    );

    assign GNT0     = gnt[0];
    assign GNT1     = gnt[1];
    assign BUSY     = (state_q == ST_CLEAR);
    assign RAM_EN   = ram_en_q;
    assign RAM_WE   = ram_we_q;
    assign RAM_ADDR = ram_addr_q;
    assign RAM_DI   = ram_di_q;
    assign RAM_DIP  = ram_dip_q;
    assign RVALID0  = rvalid_q[0];
    assign RVALID1  = rvalid_q[1];
    // RAM output register is off, so read data is valid the cycle after the RAM access
    assign RDATA0   = {RAM_DOP, RAM_DO};
    assign RDATA1   = {RAM_DOP, RAM_DO};

    // Next-state: clear sweep, or register the accepted access onto the RAM port
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        ram_en_d   = 1'b0;
        ram_we_d   = '0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        ram_dip_d  = ram_dip_q;
        rd_d       = 1'b0;
        rd_id_d    = rd_id_q;
        rvalid_d   = {rd_q & rd_id_q, rd_q & ~rd_id_q};

        case (state_q)
            ST_CLEAR: begin
                ram_en_d   = 1'b1;
                ram_we_d   = '1;
                ram_addr_d = clr_cnt_q;
                ram_di_d   = '0;
                ram_dip_d  = '0;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (REQ0 && gnt[0]) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = WR0 ? BE0 : '0;
                    ram_addr_d = ADDR0;
                    ram_di_d   = DI0;
                    ram_dip_d  = DIP0;
                    rd_d       = ~WR0;
                    rd_id_d    = 1'b0;
                end else if (REQ1 && gnt[1]) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = WR1 ? BE1 : '0;
                    ram_addr_d = ADDR1;
                    ram_di_d   = DI1;
                    ram_dip_d  = DIP1;
                    rd_d       = ~WR1;
                    rd_id_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, RAM port and read-return pipeline registers; reset drops all in-flight work
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q  <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            ram_dip_q  <= '0;
            rd_q       <= 1'b0;
            rd_id_q    <= 1'b0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_dip_q  <= ram_dip_d;
            rd_q       <= rd_d;
            rd_id_q    <= rd_id_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_ramb16_port_arb.sv
// tb/tb_ramb16_port_arb.sv - scoreboard bench for the RAMB16 port arbiter with a behavioural RAM
module tb_ramb16_port_arb;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int PW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          REQ0 = 0, REQ1 = 0, WR0 = 0, WR1 = 0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] DI0 = '0, DI1 = '0;
    logic [PW-1:0] DIP0 = '0, DIP1 = '0, BE0 = '0, BE1 = '0;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [DW+PW-1:0] RDATA0, RDATA1;
    logic          RAM_EN;
    logic [PW-1:0] RAM_WE, RAM_DIP;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DI;
    logic [DW-1:0] RAM_DO = '0;
    logic [PW-1:0] RAM_DOP = '0;
    logic          BUSY;

    ramb16_port_arb #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .DI0(DI0), .DI1(DI1),
        .DIP0(DIP0), .DIP1(DIP1), .BE0(BE0), .BE1(BE1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DIP(RAM_DIP), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAMB16 port, read-first, no output register
    logic [DW-1:0] mem_d [0:(1<<AW)-1];
    logic [PW-1:0] mem_p [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_d[i] = $urandom;
            mem_p[i] = PW'($urandom);
        end
    end

    always @(posedge CLK) begin
        if (RAM_EN) begin
            RAM_DO  <= mem_d[RAM_ADDR];
            RAM_DOP <= mem_p[RAM_ADDR];
            for (int b = 0; b < PW; b++) begin
                if (RAM_WE[b]) begin
                    mem_d[RAM_ADDR][8*b +: 8] <= RAM_DI[8*b +: 8];
                    mem_p[RAM_ADDR][b]        <= RAM_DIP[b];
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_cnt   = 0;

    always @(posedge CLK) cyc = cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [DW+PW-1:0] data;
        int               due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Monitor: every read return is popped and compared against the scoreboard
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_N) begin
            if (RVALID0) begin
                rv_cnt++;
                if (q0.size() == 0) begin
                    check("rvalid0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("rdata0", RDATA0, e.data);
                    check("rlat0", cyc, e.due);
                end
            end
            if (RVALID1) begin
                rv_cnt++;
                if (q1.size() == 0) begin
                    check("rvalid1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("rdata1", RDATA1, e.data);
                    check("rlat1", cyc, e.due);
                end
            end
        end
    end

    // Issue one access and hold it until granted; returns one cycle after acceptance with REQ still up
    task automatic access(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [PW-1:0] dp,
                          input logic [PW-1:0] be, input logic [DW+PW-1:0] exp,
                          output int waited);
        exp_t e;
        bit   ok;
        if (p == 0) begin
            REQ0 = 1; WR0 = wr; ADDR0 = a; DI0 = d; DIP0 = dp; BE0 = be;
        end else begin
            REQ1 = 1; WR1 = wr; ADDR1 = a; DI1 = d; DIP1 = dp; BE1 = be;
        end
        waited = 0;
        ok = 0;
        while (!ok) begin
            @(negedge CLK);
            if ((p == 0 && GNT0) || (p == 1 && GNT1)) begin
                ok = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check("grant_timeout", 0, 1);
                    break;
                end
            end
        end
        if (ok && !wr) begin
            e.data = exp;
            e.due  = cyc + 2;
            if (p == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        REQ0 = 0;
        REQ1 = 0;
    endtask

    // Follow a clear sweep; stop_at >= 0 returns right after that address is written
    task automatic wait_clear(input int stop_at, input bit exp_gnt0);
        int busy_n = 0;
        int nxt    = 0;
        int bad    = 0;
        int guard  = 0;
        while (guard < 700) begin
            @(negedge CLK);
            guard++;
            if (BUSY) begin
                busy_n++;
                if (GNT0 || GNT1) bad++;
            end
            if (RAM_EN) begin
                if (RAM_WE != 4'hF || RAM_DI != '0 || RAM_DIP != '0 || RAM_ADDR != nxt[AW-1:0]) bad++;
                nxt++;
            end
            if (stop_at >= 0 && nxt == stop_at + 1) return;
            if (!BUSY && nxt >= 512) break;
        end
        check("clear_busy_cycles", busy_n, 512);
        check("clear_writes", nxt, 512);
        check("clear_bad_cycles", bad, 0);
        check("gnt0_after_clear", GNT0, exp_gnt0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_en"},   RAM_EN, 0);
        check({tag, "_ram_we"},   RAM_WE, 0);
        check({tag, "_ram_addr"}, RAM_ADDR, 0);
        check({tag, "_ram_di"},   {RAM_DIP, RAM_DI}, 0);
        check({tag, "_gnt"},      {GNT1, GNT0}, 0);
        check({tag, "_rvalid"},   {RVALID1, RVALID0}, 0);
        check({tag, "_busy"},     BUSY, 1);
    endtask

    initial begin : stim
        int   w;
        int   rv_before;
        exp_t e;

        #1 RST_N = 0;
        #2 check_reset_outputs("reset");

        // Pending REQ0 read across the whole clear; granted on the first RUN cycle
        REQ0 = 1; WR0 = 0; ADDR0 = 9'h000; BE0 = 4'hF;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1;
        wait_clear(-1, 1'b1);
        e.data = '0;
        e.due  = cyc + 2;
        q0.push_back(e);
        @(posedge CLK);
        #1 idle();

        // Single requester: full-word write then read back
        access(0, 1, 9'h1F0, 32'hDEADBEEF, 4'h0, 4'hF, '0, w);
        check("single_req_wait", w, 0);
        access(0, 0, 9'h1F0, '0, '0, '0, 36'h0_DEADBEEF, w);
        idle();
        repeat (2) @(posedge CLK);
        #1;

        // Byte-enable boundaries on cleared words
        access(0, 1, 9'h010, 32'h00AB0000, 4'h0, 4'b0010, '0, w);
        access(0, 0, 9'h010, '0, '0, '0, 36'h0_00000000, w);
        access(0, 1, 9'h020, 32'h00AB0000, 4'hF, 4'b0100, '0, w);
        access(0, 0, 9'h020, '0, '0, '0, 36'h4_00AB0000, w);
        // Back-to-back write then read of the same word
        access(0, 1, 9'h030, 32'hCAFEF00D, 4'h3, 4'hF, '0, w);
        access(0, 0, 9'h030, '0, '0, '0, 36'h3_CAFEF00D, w);
        idle();

        // Requester 1 alone
        access(1, 1, 9'h005, 32'h12345678, 4'hA, 4'hF, '0, w);
        access(1, 0, 9'h005, '0, '0, '0, 36'hA_12345678, w);
        idle();
        repeat (3) @(posedge CLK);
        #1;

        // Both requesting continuously: strict alternation starting with 0
        REQ0 = 1; WR0 = 0; ADDR0 = 9'h1F0;
        REQ1 = 1; WR1 = 0; ADDR1 = 9'h005;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("alt_gnt0", GNT0, (i % 2) == 0);
            check("alt_gnt1", GNT1, (i % 2) == 1);
            if (GNT0) begin
                e.data = 36'h0_DEADBEEF; e.due = cyc + 2; q0.push_back(e);
            end
            if (GNT1) begin
                e.data = 36'hA_12345678; e.due = cyc + 2; q1.push_back(e);
            end
            @(posedge CLK);
            #1;
        end
        idle();
        repeat (4) @(posedge CLK);
        #1;
        check("queues_drained", q0.size() + q1.size(), 0);

        // Reset pulse in the middle of a clear sweep
        RST_N = 0;
        @(posedge CLK);
        #1 RST_N = 1;
        wait_clear(100, 1'b0);
        #2 RST_N = 0;
        #1 check_reset_outputs("midclear");
        @(posedge CLK);
        #1 RST_N = 1;
        wait_clear(-1, 1'b0);
        @(posedge CLK);
        #1;

        // Reset between read acceptance and its return: the return must never appear
        access(0, 0, 9'h1F0, '0, '0, '0, '0, w);
        idle();
        RST_N = 0;
        q0.delete();
        rv_before = rv_cnt;
        @(posedge CLK);
        #1 RST_N = 1;
        wait_clear(-1, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        check("no_rvalid_after_reset", rv_cnt, rv_before);
        check("final_queues_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
